// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: word width, bubble
// encoding, FSM state type and a word-alignment helper.
package if_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

  typedef enum logic {
    S_BOOT,
    S_FETCH
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory port shared between the fetch stage (master) and the
// unified memory (slave).
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic [XLEN-1:0] imem_rdata_i;
  logic            mem_busy_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_rdata_i,
    input  mem_busy_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_rdata_i,
    output mem_busy_i
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched word that could not enter IF/ID.
// clear beats load, load beats drain (a drain and refill in the same cycle
// leaves the entry valid with the new word).
module fetch_skid_buffer
  import if_fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            drain,
  input  logic            clear,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  // Entry state: flush on reset/clear, capture on load, empty on drain.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  // Payload only matters while valid, so it is captured on load alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr <= '0;
      pc    <= '0;
    end else if (load && !clear) begin
      instr <= load_instr;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests words from the shared
// memory (yielding to MEM), and fills the IF/ID register, parking one
// returning word in a skid entry when decode stalls.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = if_fetch_stage_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  if_fetch_stage_if.master  imem,
  output logic              ifid_valid_o,
  output logic [XLEN-1:0]   ifid_instr_o,
  output logic [6:0]        ifid_opcode_o,
  output logic [XLEN-1:0]   ifid_pc_o,
  output logic [XLEN-1:0]   ifid_pc4_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic            inflight_q;
  logic            kill_q;
  logic            req;
  logic            accept;
  logic            live;

  logic            skid_valid;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic            skid_load;
  logic            skid_drain;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus request/accept/live-data decode.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    accept  = 1'b0;
    live    = 1'b0;
    unique case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: state_d = S_FETCH;
      default: state_d = S_BOOT;
    endcase
    // Holding the request while a stalled word is in flight or parked in
    // skid is what keeps the single skid entry from ever overflowing.
    req    = rst_n && (state_q == S_FETCH) && !redirect_i && !skid_valid
             && !(inflight_q && stall_i);
    accept = req && !imem.mem_busy_i;
    live   = inflight_q && !kill_q;
  end

  // PC and outstanding-request tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_q    <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      inflight_q <= accept;
      kill_q     <= redirect_i && inflight_q;
      if (accept) begin
        inflight_pc_q <= pc_q;
      end
      if (redirect_i) begin
        pc_q <= word_align(redirect_pc_i);
      end else if (accept) begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

  assign skid_load  = live && !redirect_i && (stall_i || skid_valid);
  assign skid_drain = !redirect_i && !stall_i && skid_valid;

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (skid_load),
    .drain      (skid_drain),
    .clear      (redirect_i),
    .load_instr (imem.imem_rdata_i),
    .load_pc    (inflight_pc_q),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // IF/ID register: flush on redirect, hold on stall, else skid > live > bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifid_valid_o <= 1'b0;
      ifid_instr_o <= NOP_INSTR;
      ifid_pc_o    <= RESET_PC;
    end else if (redirect_i) begin
      ifid_valid_o <= 1'b0;
      ifid_instr_o <= NOP_INSTR;
    end else if (!stall_i) begin
      if (skid_valid) begin
        ifid_valid_o <= 1'b1;
        ifid_instr_o <= skid_instr;
        ifid_pc_o    <= skid_pc;
      end else if (live) begin
        ifid_valid_o <= 1'b1;
        ifid_instr_o <= imem.imem_rdata_i;
        ifid_pc_o    <= inflight_pc_q;
      end else begin
        ifid_valid_o <= 1'b0;
        ifid_instr_o <= NOP_INSTR;
      end
    end
  end

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = pc_q;
  assign ifid_opcode_o    = ifid_instr_o[6:0];
  assign ifid_pc4_o       = ifid_pc_o + 32'd4;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a cycle table covering boot, mem_busy,
// stall/skid, redirects and mid-stream reset, then a PC wrap sequence.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_instr_o;
  logic [6:0]  ifid_opcode_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc4_o;

  int unsigned checks;
  int unsigned errors;

  if_fetch_stage_if imem_bus ();

  if_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (imem_bus),
    .ifid_valid_o  (ifid_valid_o),
    .ifid_instr_o  (ifid_instr_o),
    .ifid_opcode_o (ifid_opcode_o),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_pc4_o    (ifid_pc4_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory responder: accepted request answered one cycle later, junk otherwise.
  initial imem_bus.imem_rdata_i = 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (imem_bus.imem_req_o && !imem_bus.mem_busy_i)
      imem_bus.imem_rdata_i <= memword(imem_bus.imem_addr_o);
    else
      imem_bus.imem_rdata_i <= 32'hDEAD_BEEF;
  end

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        busy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(input logic r, input logic s, input logic d,
                              input logic [31:0] rp, input logic b,
                              input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
    vec_t v;
    v.rst_n = r; v.stall = s; v.redir = d; v.rpc = rp; v.busy = b;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
    return v;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input logic er, input logic [31:0] ea,
                             input logic ev, input logic [31:0] ep);
    logic [31:0] ei;
    ei = ev ? memword(ep) : NOP;
    compare({tag, ".req"},    {31'd0, imem_bus.imem_req_o}, {31'd0, er});
    compare({tag, ".addr"},   imem_bus.imem_addr_o, ea);
    compare({tag, ".valid"},  {31'd0, ifid_valid_o}, {31'd0, ev});
    compare({tag, ".instr"},  ifid_instr_o, ei);
    compare({tag, ".opcode"}, {25'd0, ifid_opcode_o}, {25'd0, ei[6:0]});
    compare({tag, ".pc"},     ifid_pc_o, ep);
    compare({tag, ".pc4"},    ifid_pc4_o, ep + 32'd4);
  endtask

  task automatic drive(input logic r, input logic s, input logic d,
                       input logic [31:0] rp, input logic b);
    rst_n = r; stall_i = s; redirect_i = d; redirect_pc_i = rp;
    imem_bus.mem_busy_i = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    //            rst stl rdr rpc           bsy   req addr          vld pc
    vecs[0]  = mk(0,  0,  0,  32'h0,        0,    0,  32'h0000_0000, 0, 32'h0000_0000); // reset
    vecs[1]  = mk(1,  0,  0,  32'h0,        0,    0,  32'h0000_0000, 0, 32'h0000_0000); // boot
    vecs[2]  = mk(1,  0,  0,  32'h0,        0,    1,  32'h0000_0000, 0, 32'h0000_0000);
    vecs[3]  = mk(1,  0,  0,  32'h0,        0,    1,  32'h0000_0004, 0, 32'h0000_0000);
    vecs[4]  = mk(1,  0,  0,  32'h0,        0,    1,  32'h0000_0008, 1, 32'h0000_0000);
    vecs[5]  = mk(1,  0,  0,  32'h0,        0,    1,  32'h0000_000C, 1, 32'h0000_0004);
    vecs[6]  = mk(1,  0,  0,  32'h0,        1,    1,  32'h0000_0010, 1, 32'h0000_0008); // busy x3
    vecs[7]  = mk(1,  0,  0,  32'h0,        1,    1,  32'h0000_0010, 1, 32'h0000_000C);
    vecs[8]  = mk(1,  0,  0,  32'h0,        1,    1,  32'h0000_0010, 0, 32'h0000_000C);
    vecs[9]  = mk(1,  0,  0,  32'h0,        0,    1,  32'h0000_0010, 0, 32'h0000_000C);
    vecs[10] = mk(1,  0,  0,  32'h0,        0,    1,  32'h0000_0014, 0, 32'h0000_000C);
    vecs[11] = mk(1,  1,  0,  32'h0,        0,    0,  32'h0000_0018, 1, 32'h0000_0010); // stall x2
    vecs[12] = mk(1,  1,  0,  32'h0,        0,    0,  32'h0000_0018, 1, 32'h0000_0010);
    vecs[13] = mk(1,  0,  0,  32'h0,        0,    0,  32'h0000_0018, 1, 32'h0000_0010);
    vecs[14] = mk(1,  0,  0,  32'h0,        0,    1,  32'h0000_0018, 1, 32'h0000_0014);
    vecs[15] = mk(1,  0,  0,  32'h0,        0,    1,  32'h0000_001C, 0, 32'h0000_0014);
    vecs[16] = mk(1,  0,  0,  32'h0,        0,    1,  32'h0000_0020, 1, 32'h0000_0018);
    vecs[17] = mk(1,  1,  0,  32'h0,        0,    0,  32'h0000_0024, 1, 32'h0000_001C); // fill skid
    vecs[18] = mk(1,  0,  1,  32'h103,      0,    0,  32'h0000_0024, 1, 32'h0000_001C); // redirect
    vecs[19] = mk(1,  0,  0,  32'h0,        0,    1,  32'h0000_0100, 0, 32'h0000_001C);
    vecs[20] = mk(1,  0,  0,  32'h0,        0,    1,  32'h0000_0104, 0, 32'h0000_001C);
    vecs[21] = mk(1,  1,  1,  32'h40,       0,    0,  32'h0000_0108, 1, 32'h0000_0100); // redir+stall
    vecs[22] = mk(1,  0,  0,  32'h0,        0,    1,  32'h0000_0040, 0, 32'h0000_0100);
    vecs[23] = mk(1,  0,  0,  32'h0,        0,    1,  32'h0000_0044, 0, 32'h0000_0100);
    vecs[24] = mk(1,  0,  0,  32'h0,        0,    1,  32'h0000_0048, 1, 32'h0000_0040);
    vecs[25] = mk(0,  0,  0,  32'h0,        0,    0,  32'h0000_004C, 1, 32'h0000_0044); // reset pulse
    vecs[26] = mk(1,  0,  0,  32'h0,        0,    0,  32'h0000_0000, 0, 32'h0000_0000);
    vecs[27] = mk(1,  0,  0,  32'h0,        0,    1,  32'h0000_0000, 0, 32'h0000_0000);
    vecs[28] = mk(1,  0,  0,  32'h0,        0,    1,  32'h0000_0004, 0, 32'h0000_0000);
    vecs[29] = mk(1,  0,  0,  32'h0,        0,    1,  32'h0000_0008, 1, 32'h0000_0000);

    repeat (2) tick();

    for (int i = 0; i < 30; i++) begin
      drive(vecs[i].rst_n, vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].busy);
      #1;
      check_cycle($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                  vecs[i].exp_valid, vecs[i].exp_pc);
      tick();
    end

    // Redirect to the top word while MEM owns memory, then wrap past 2^32.
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b1);
    #1; check_cycle("wrap0", 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    #1; check_cycle("wrap1", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0004);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    #1; check_cycle("wrap2", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0004);
    tick();
    #1; check_cycle("wrap3", 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0004);
    tick();
    #1; check_cycle("wrap4", 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the single-memory pipelined RV32I core. Owns the PC and issues fetch requests to the shared unified memory.
- Yields the memory whenever the MEM stage is using it.
- Drives the IF/ID pipeline register (instruction, opcode, PC) consumed by decode, including the immediate generator.
- Absorbs one returning word in a skid entry so decode stalls never lose a fetched instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stall_i  in  1  decode hazard stall; hold IF/ID.
- redirect_i  in  1  taken branch/jump from EX; flush and reload PC.
- redirect_pc_i  in  32  target PC for redirect.
- mem_busy_i  in  1  MEM stage owns the memory this cycle; fetch request is not accepted.
- imem_req_o  in/out: out  1  fetch request.
- imem_addr_o  out  32  fetch word address, equal to the PC register.
- imem_rdata_i  in  32  read data, valid exactly one cycle after an accepted request.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- ifid_instr_o  out  32  IF/ID instruction.
- ifid_opcode_o  out  7  ifid_instr_o[6:0].
- ifid_pc_o  out  32  PC of the IF/ID instruction.
- ifid_pc4_o  out  32  ifid_pc_o + 4 (mod 2^32).

Behaviour:
- Reset (rst_n low at an edge):
  - pc = RESET_PC, state = S_BOOT, inflight = 0, kill = 0, skid_valid = 0.
  - ifid_valid_o = 0, ifid_instr_o = NOP_INSTR, ifid_opcode_o = 7'b0010011, ifid_pc_o = RESET_PC.
  - imem_req_o = 0 while in reset.
  - Reset overrides every other input. Reset asserted mid-operation discards in-flight and skid data.
- FSM states:
  - S_BOOT: one cycle after reset release, no request, then go to S_FETCH.
  - S_FETCH: normal operation; remains there permanently.
- Request rule:
  - imem_req_o = (state==S_FETCH) && !redirect_i && !skid_valid && !(inflight && stall_i).
  - accept = imem_req_o && !mem_busy_i.
  - On accept: pc += 4 (wraps at 2^32), inflight_pc <= pc, inflight <= 1. Otherwise inflight <= 0.
- Returning data:
  - When inflight is 1, imem_rdata_i is the word for inflight_pc in the current cycle.
  - If kill is set, the word is discarded.
- Redirect (highest priority after reset, overrides stall_i):
  - pc <= {redirect_pc_i[31:2],2'b00}.
  - ifid_valid_o <= 0 and ifid_instr_o <= NOP_INSTR.
  - skid_valid <= 0; kill <= inflight (a word returning next cycle is discarded). No request is issued that cycle.
- IF/ID update when !stall_i and no redirect:
  - If skid_valid: IF/ID loads the skid entry. A word returning in the same cycle goes into skid, otherwise skid_valid <= 0.
  - Else if a live word returns: IF/ID loads it, valid = 1.
  - Else: bubble (valid = 0, instr = NOP_INSTR, pc unchanged).
- When stall_i and no redirect:
  - IF/ID holds.
  - A live returning word goes into skid (skid_valid <= 1).
  - The request rule guarantees skid never overflows.
- mem_busy_i for N cycles: the PC holds and the request stays asserted with a stable address. IF/ID receives bubbles once the skid and in-flight word are drained.
- Fetch-to-IF/ID latency is 2 cycles with no stalls. Steady-state throughput is 1 instruction per cycle.

Decomposition:
- Shared package/defines: NOP_INSTR, opcode constants, state encodings S_BOOT/S_FETCH, XLEN = 32.
- One natural sub-module: fetch_skid_buffer (1-entry {instr,pc,valid} holding register with load/drain/clear).

Test Plan:
- Reset release with RESET_PC=0 and memory returning words 0..N:
  - Addresses 0x0, 0x4, 0x8 are issued on consecutive cycles.
  - ifid_instr_o for PC 0 appears 2 cycles after the first accept.
  - valid = 1 every cycle thereafter.
- mem_busy_i high 3 cycles at address 0x10:
  - imem_addr_o stays 0x10 and imem_req_o stays 1.
  - Exactly 3 bubbles are visible after the pipeline drains.
  - The instruction from 0x10 follows them; no PC is skipped or duplicated.
- stall_i high 2 cycles while a word is in flight:
  - The word is captured in skid and no new request is issued.
  - After release, IF/ID shows held, then skid, then the next PC in order.
- redirect_i with redirect_pc_i=0x103 while in flight and skid full:
  - The next request address is 0x100.
  - The in-flight word is dropped and IF/ID shows a NOP bubble with valid = 0.
  - The first valid instruction has PC 0x100.
- redirect_i and stall_i asserted together: the redirect wins, and IF/ID is flushed to NOP.
- rst_n low for 1 cycle mid-stream with a request accepted:
  - All outputs return to reset values.
  - The returning word is ignored and fetch restarts at RESET_PC after S_BOOT.
